// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-1 style microcode controller.
// Opcode values, T-state encoding, control-word bit positions and the idle word.
// Imported by the step counter and the decode top level.
package sap_pkg;

  localparam int NUM_STEPS = 5;
  localparam int CTRL_W    = 13;

  // Instruction opcodes (upper nibble of the instruction register)
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // T-states of one instruction
  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  // Bit positions inside the active-low control word
  localparam int CO_N = 12;
  localparam int MI_N = 11;
  localparam int RO_N = 10;
  localparam int RI_N = 9;
  localparam int II_N = 8;
  localparam int IO_N = 7;
  localparam int AI_N = 6;
  localparam int AO_N = 5;
  localparam int BI_N = 4;
  localparam int EO_N = 3;
  localparam int FI_N = 2;
  localparam int J_N  = 1;
  localparam int OI_N = 0;

  // Every strobe inactive
  localparam logic [CTRL_W-1:0] CTRL_IDLE = '1;

endpackage

// File: rtl/sap_step_counter.sv
// T-state counter: cycles T0..T4, freezes at T2 once a halt is requested.
// The halted state is sticky and only cleared by the asynchronous reset.
// Reset forces T0 immediately, abandoning any instruction in flight.
module sap_step_counter
  import sap_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  halt_req,
  output step_t step,
  output logic  halted
);

  // Advance one T-state per clock unless halting; halting latches forever
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step   <= T0;
      halted <= 1'b0;
    end else if (halted || halt_req) begin
      halted <= 1'b1;
    end else begin
      case (step)
        T0:      step <= T1;
        T1:      step <= T2;
        T2:      step <= T3;
        T3:      step <= T4;
        default: step <= T0;
      endcase
    end
  end

endmodule

// File: rtl/sap_controller.sv
// SAP-1 microcode controller: decodes T-state, opcode and flags into control strobes.
// Outputs are combinational from the registered step/halt state (zero added latency).
// No backpressure; HLT freezes the sequencer at T2 until reset.
module sap_controller
  import sap_pkg::*;
#(
  parameter int NUM_STEPS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic [1:0]  flags,
  output logic [12:0] ctrl_n,
  output logic        ce,
  output logic        su,
  output logic        hlt,
  output logic [2:0]  step
);

  step_t cur_step;
  logic  halted;
  logic  halt_req;

  // HLT takes effect during its own T2 so the indicator rises with no delay
  assign halt_req = (cur_step == T2) && (opcode == OP_HLT);
  assign hlt      = halted || halt_req;
  assign step     = cur_step;

  sap_step_counter u_step (
    .clk      (clk),
    .rst_n    (rst_n),
    .halt_req (halt_req),
    .step     (cur_step),
    .halted   (halted)
  );

  // Microcode decode; anything not explicitly enabled stays inactive
  always_comb begin
    ctrl_n = CTRL_IDLE;
    ce     = 1'b0;
    su     = 1'b0;
    if (!halted) begin
      case (cur_step)
        T0: begin
          ctrl_n[CO_N] = 1'b0;
          ctrl_n[MI_N] = 1'b0;
        end
        T1: begin
          ctrl_n[RO_N] = 1'b0;
          ctrl_n[II_N] = 1'b0;
          ce           = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ctrl_n[IO_N] = 1'b0;
              ctrl_n[MI_N] = 1'b0;
            end
            OP_LDI: begin
              ctrl_n[IO_N] = 1'b0;
              ctrl_n[AI_N] = 1'b0;
            end
            OP_JMP: begin
              ctrl_n[IO_N] = 1'b0;
              ctrl_n[J_N]  = 1'b0;
            end
            OP_JC: begin
              // carry is only looked at here, so later flag changes are ignored
              ctrl_n[IO_N] = !flags[1];
              ctrl_n[J_N]  = !flags[1];
            end
            OP_JZ: begin
              ctrl_n[IO_N] = !flags[0];
              ctrl_n[J_N]  = !flags[0];
            end
            OP_OUT: begin
              ctrl_n[AO_N] = 1'b0;
              ctrl_n[OI_N] = 1'b0;
            end
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              ctrl_n[RO_N] = 1'b0;
              ctrl_n[AI_N] = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              ctrl_n[RO_N] = 1'b0;
              ctrl_n[BI_N] = 1'b0;
              su           = (opcode == OP_SUB);
            end
            OP_STA: begin
              ctrl_n[AO_N] = 1'b0;
              ctrl_n[RI_N] = 1'b0;
            end
            default: ;
          endcase
        end
        T4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            ctrl_n[EO_N] = 1'b0;
            ctrl_n[AI_N] = 1'b0;
            ctrl_n[FI_N] = 1'b0;
            su           = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_controller.sv
// Directed bench for sap_controller with hand-computed control words.
// Samples outputs on the falling edge, drives inputs at the falling edge.
// Prints one summary line and finishes.
module tb_sap_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  opcode;
  logic [1:0]  flags;
  logic [12:0] ctrl_n;
  logic        ce;
  logic        su;
  logic        hlt;
  logic [2:0]  step;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sap_controller #(.NUM_STEPS(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .opcode (opcode),
    .flags  (flags),
    .ctrl_n (ctrl_n),
    .ce     (ce),
    .su     (su),
    .hlt    (hlt),
    .step   (step)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Bus drivers: co_n, ro_n, io_n, ao_n, eo_n -- at most one may be low
  task automatic check_bus(input string tag);
    int lows;
    lows = int'(!ctrl_n[12]) + int'(!ctrl_n[10]) + int'(!ctrl_n[7]) +
           int'(!ctrl_n[5]) + int'(!ctrl_n[3]);
    check({tag, " bus_conflict"}, 16'(lows > 1), 16'd0);
  endtask

  // Runs one full instruction starting at a falling edge where step==0.
  // exp packs T0..T4 control words, most significant first.
  task automatic run_instr(input string name, input logic [3:0] op,
                           input logic [1:0] fl, input logic [1:0] fl_late,
                           input logic [64:0] exp, input logic [4:0] ce_m,
                           input logic [4:0] su_m);
    opcode = op;
    flags  = fl;
    #1;
    for (int s = 0; s < 5; s++) begin
      check($sformatf("%s T%0d step", name, s), 16'(step), 16'(s));
      check($sformatf("%s T%0d ctrl_n", name, s), 16'(ctrl_n), 16'(exp[(4-s)*13 +: 13]));
      check($sformatf("%s T%0d ce", name, s), 16'(ce), 16'(ce_m[s]));
      check($sformatf("%s T%0d su", name, s), 16'(su), 16'(su_m[s]));
      check($sformatf("%s T%0d hlt", name, s), 16'(hlt), 16'd0);
      check_bus($sformatf("%s T%0d", name, s));
      @(negedge clk);
      if (s == 2) flags = fl_late;
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    opcode = 4'h1;
    flags  = 2'b00;
    #3;
    check("reset step", 16'(step), 16'd0);
    check("reset hlt", 16'(hlt), 16'd0);
    check("reset ctrl_n", 16'(ctrl_n), 16'h07FF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //                        op    fl     late   T0       T1       T2       T3       T4          ce        su
    run_instr("LDA",  4'h1, 2'b00, 2'b00, {13'h07FF, 13'h1AFF, 13'h177F, 13'h1BBF, 13'h1FFF}, 5'b00010, 5'b00000);
    run_instr("ADD",  4'h2, 2'b00, 2'b00, {13'h07FF, 13'h1AFF, 13'h177F, 13'h1BEF, 13'h1FB3}, 5'b00010, 5'b00000);
    run_instr("SUB",  4'h3, 2'b00, 2'b00, {13'h07FF, 13'h1AFF, 13'h177F, 13'h1BEF, 13'h1FB3}, 5'b00010, 5'b11000);
    run_instr("STA",  4'h4, 2'b00, 2'b00, {13'h07FF, 13'h1AFF, 13'h177F, 13'h1DDF, 13'h1FFF}, 5'b00010, 5'b00000);
    run_instr("LDI",  4'h5, 2'b00, 2'b00, {13'h07FF, 13'h1AFF, 13'h1F3F, 13'h1FFF, 13'h1FFF}, 5'b00010, 5'b00000);
    run_instr("JMP",  4'h6, 2'b00, 2'b00, {13'h07FF, 13'h1AFF, 13'h1F7D, 13'h1FFF, 13'h1FFF}, 5'b00010, 5'b00000);
    run_instr("JCt",  4'h7, 2'b10, 2'b10, {13'h07FF, 13'h1AFF, 13'h1F7D, 13'h1FFF, 13'h1FFF}, 5'b00010, 5'b00000);
    run_instr("JCf",  4'h7, 2'b00, 2'b10, {13'h07FF, 13'h1AFF, 13'h1FFF, 13'h1FFF, 13'h1FFF}, 5'b00010, 5'b00000);
    run_instr("JZt",  4'h8, 2'b01, 2'b00, {13'h07FF, 13'h1AFF, 13'h1F7D, 13'h1FFF, 13'h1FFF}, 5'b00010, 5'b00000);
    run_instr("JZf",  4'h8, 2'b10, 2'b01, {13'h07FF, 13'h1AFF, 13'h1FFF, 13'h1FFF, 13'h1FFF}, 5'b00010, 5'b00000);
    run_instr("OUT",  4'hE, 2'b00, 2'b00, {13'h07FF, 13'h1AFF, 13'h1FDE, 13'h1FFF, 13'h1FFF}, 5'b00010, 5'b00000);
    run_instr("NOP9", 4'h9, 2'b11, 2'b11, {13'h07FF, 13'h1AFF, 13'h1FFF, 13'h1FFF, 13'h1FFF}, 5'b00010, 5'b00000);
    run_instr("NOP0", 4'h0, 2'b00, 2'b00, {13'h07FF, 13'h1AFF, 13'h1FFF, 13'h1FFF, 13'h1FFF}, 5'b00010, 5'b00000);

    // HLT: fetch normally, then freeze at T2
    opcode = 4'hF;
    flags  = 2'b00;
    @(negedge clk); #1;
    check("HLT T1 step", 16'(step), 16'd1);
    check("HLT T1 hlt", 16'(hlt), 16'd0);
    @(negedge clk); #1;
    check("HLT T2 step", 16'(step), 16'd2);
    check("HLT T2 hlt", 16'(hlt), 16'd1);
    check("HLT T2 ctrl_n", 16'(ctrl_n), 16'h1FFF);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5) opcode = 4'h1;  // a different opcode must not release the halt
      #1;
      check($sformatf("HALT c%0d step", i), 16'(step), 16'd2);
      check($sformatf("HALT c%0d hlt", i), 16'(hlt), 16'd1);
      check($sformatf("HALT c%0d ctrl_n", i), 16'(ctrl_n), 16'h1FFF);
      check($sformatf("HALT c%0d ce_su", i), 16'({ce, su}), 16'd0);
    end
    #1 rst_n = 1'b0;
    #1;
    check("HALT reset step", 16'(step), 16'd0);
    check("HALT reset hlt", 16'(hlt), 16'd0);
    check("HALT reset ctrl_n", 16'(ctrl_n), 16'h07FF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("post-halt T1 step", 16'(step), 16'd1);

    // Async reset in the middle of ADD T3
    @(negedge clk);
    while (step != 3'd0) @(negedge clk);
    opcode = 4'h2;
    repeat (3) @(negedge clk);
    #1;
    check("ADD mid T3 step", 16'(step), 16'd3);
    check("ADD mid T3 ctrl_n", 16'(ctrl_n), 16'h1BEF);
    #1 rst_n = 1'b0;
    #1;
    check("async reset step", 16'(step), 16'd0);
    check("async reset ctrl_n", 16'(ctrl_n), 16'h07FF);
    check("async reset ce", 16'(ce), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release step", 16'(step), 16'd0);
    @(negedge clk); #1;
    check("release T1 step", 16'(step), 16'd1);
    check("release T1 ctrl_n", 16'(ctrl_n), 16'h1AFF);
    check("release T1 ce", 16'(ce), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sap_controller.md
SAP_CONTROLLER -- requirements
Module: sap_controller

Interface
REQ-001 Parameter: NUM_STEPS, 5, number of T-states per instruction (T0..T4); fixed at 5, other values unsupported.
REQ-002 Port: clk  input  1  system clock; all state advances on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: opcode  input  4  instruction register upper nibble.
REQ-005 Port: flags  input  2  ALU flag_out; bit1 carry, bit0 zero.
REQ-006 Port: ctrl_n  output  13  active-low strobes: [12]co_n PC-out, [11]mi_n MAR-in, [10]ro_n RAM-out, [9]ri_n RAM-in, [8]ii_n IR-in, [7]io_n IR-out, [6]ai_n A-in, [5]ao_n A-out, [4]bi_n B-in, [3]eo_n ALU-out (ALU enable), [2]fi_n flags-update, [1]j_n PC-load, [0]oi_n OUT-in.
REQ-007 Port: ce  output  1  PC count enable, active-high.
REQ-008 Port: su  output  1  ALU subtract select, active-high.
REQ-009 Port: hlt  output  1  halted indicator, active-high.
REQ-010 Port: step  output  3  current T-state, for debug.

Function
REQ-011 Step counter SHALL count 0..4 on each rising clk edge, wrapping 4->0; no early termination.
REQ-012 Outputs SHALL be combinational decode of registered step, halted state, opcode and flags; no registered output latency.
REQ-013 Fetch for every opcode: T0 co_n=0, mi_n=0; T1 ro_n=0, ii_n=0, ce=1.
REQ-014 Opcodes: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 LDI, 6 JMP, 7 JC, 8 JZ, E OUT, F HLT; 9-D decode as NOP.
REQ-015 LDA: T2 io_n,mi_n; T3 ro_n,ai_n.
REQ-016 ADD: T2 io_n,mi_n; T3 ro_n,bi_n; T4 eo_n,ai_n,fi_n, su=0.
REQ-017 SUB: as ADD but su=1 during T3 and T4.
REQ-018 STA: T2 io_n,mi_n; T3 ao_n,ri_n. LDI: T2 io_n,ai_n. JMP: T2 io_n,j_n.
REQ-019 JC: T2 io_n,j_n only if flags[1]=1, else T2 inactive; JZ identical using flags[0]; flags sampled combinationally during T2.
REQ-020 OUT: T2 ao_n,oi_n.
REQ-021 All strobes not listed for a step SHALL be inactive (ctrl_n bit=1, ce=0, su=0).
REQ-022 HLT: at T2 enter HALTED; while HALTED, ctrl_n=all ones, ce=0, su=0, hlt=1, step frozen at 2; exit only by reset.
REQ-023 No two bus-driving strobes (co_n, ro_n, io_n, ao_n, eo_n) SHALL be low in the same step.
REQ-024 Flag or opcode changes outside T2 SHALL have no effect on JC/JZ outcome.

Reset
REQ-025 rst_n=0 SHALL immediately force step=0, HALTED cleared, hlt=0; outputs then show T0 fetch decode.
REQ-026 Reset asserted mid-instruction SHALL abandon it; first rising edge after release advances to T1.

Structure
REQ-027 Shared package sap_pkg SHALL hold opcode constants, step constants T0..T4, ctrl_n bit-index constants and CTRL_IDLE (all ones).
REQ-028 Step counter with halt freeze SHALL be sub-module sap_step_counter; decode stays in sap_controller.

Verification
REQ-029 Reset released, opcode=1 -> steps 0,1,2,3,4,0; T0 ctrl_n=0x07FF ... per REQ-013/015, T4 ctrl_n=0x1FFF.
REQ-030 opcode=3 -> T4: eo_n=0, ai_n=0, fi_n=0, su=1; T3 su=1, bi_n=0.
REQ-031 opcode=7 flags=2'b10 -> T2 j_n=0, io_n=0; flags=2'b00 -> T2 ctrl_n=0x1FFF.
REQ-032 opcode=8 flags=2'b01 -> T2 j_n=0; flags toggled to 2'b00 during T3 -> no j_n pulse.
REQ-033 opcode=F -> from T2: hlt=1, step stays 2 for 20 cycles, ctrl_n=0x1FFF, ce=0; rst_n pulse -> step=0, hlt=0.
REQ-034 rst_n asserted between edges during ADD T3 -> step=0 asynchronously; all steps checked for REQ-023.
